// File: rtl/cordic_rotator_if.sv
// Handshake bundle for cordic_rotator: polar sample in, I/Q result out.
// slave = rotator side, master = producer/consumer side.
interface cordic_rotator_if #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned THETA_WIDTH = 16
);
    logic signed [DATA_WIDTH-1:0]  input_data_amp;
    logic signed [THETA_WIDTH-1:0] input_data_theta;
    logic                          input_valid;
    logic                          input_ready;
    logic signed [DATA_WIDTH+1:0]  output_data_i;
    logic signed [DATA_WIDTH+1:0]  output_data_q;
    logic                          output_data_valid;
    logic                          output_ready;

    modport slave (
        input  input_data_amp, input_data_theta, input_valid, output_ready,
        output input_ready, output_data_i, output_data_q, output_data_valid
    );

    modport master (
        output input_data_amp, input_data_theta, input_valid, output_ready,
        input  input_ready, output_data_i, output_data_q, output_data_valid
    );
endinterface

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: (amp, theta) -> (I, Q), one micro-rotation per clock.
// Define CORDIC_ROTATOR_GAIN_COMP_EN to add a SCALE state that divides out the CORDIC gain.
module cordic_rotator #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned THETA_WIDTH = 16,
    parameter int unsigned ITERATIONS  = 14
) (
    input  logic            clk,
    input  logic            reset,
    cordic_rotator_if.slave bus
);
    localparam int unsigned   XW        = DATA_WIDTH + 2;
    localparam int unsigned   TW        = THETA_WIDTH;
    localparam int unsigned   IW        = $clog2(ITERATIONS);
    localparam logic [IW-1:0] LAST_ITER = IW'(ITERATIONS - 1);

`ifdef CORDIC_ROTATOR_GAIN_COMP_EN
    typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_SCALE, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_DONE} state_t;
`endif

    state_t               state_q, state_d;
    logic [IW-1:0]        iter_q, iter_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic signed [TW-1:0] z_q, z_d;
    logic signed [XW-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
    logic                 rdy_q, rdy_d, vld_q, vld_d;
    logic signed [XW-1:0] amp_ext, dx, dy;
    logic signed [TW-1:0] dz;

    // atan(2^-i)/pi scaled to 2^31, rounded to the configured angle width
    function automatic logic [TW-1:0] atan_lut(input logic [IW-1:0] idx);
        logic [63:0] b;
        case (int'(idx))
            0:       b = 64'h2000_0000;
            1:       b = 64'h12E4_051E;
            2:       b = 64'h09FB_385B;
            3:       b = 64'h0511_11D4;
            4:       b = 64'h028B_0D43;
            5:       b = 64'h0145_D7E1;
            6:       b = 64'h00A2_F61E;
            7:       b = 64'h0051_7C55;
            8:       b = 64'h0028_BE53;
            9:       b = 64'h0014_5F2F;
            10:      b = 64'h000A_2F98;
            11:      b = 64'h0005_17CC;
            12:      b = 64'h0002_8BE6;
            13:      b = 64'h0001_45F3;
            14:      b = 64'h0000_A2FA;
            15:      b = 64'h0000_517D;
            default: b = 64'd683565276 >> idx;
        endcase
        if (TW < 32) begin
            b = (b + (64'd1 << (31 - TW))) >> (32 - TW);
        end
        return TW'(b);
    endfunction

`ifdef CORDIC_ROTATOR_GAIN_COMP_EN
    // v * round(2^15/K), then >>> 15 with round-half-up
    function automatic logic signed [XW-1:0] gain_comp(input logic signed [XW-1:0] v);
        logic signed [XW+15:0] p;
        p = (XW+16)'(v) * $signed((XW+16)'(19898));
        p = p + $signed((XW+16)'(16384));
        return XW'(p >>> 15);
    endfunction
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            out_i_q <= '0;
            out_q_q <= '0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            out_i_q <= out_i_d;
            out_q_q <= out_q_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        out_i_d = out_i_q;
        out_q_d = out_q_q;
        amp_ext = XW'(bus.input_data_amp);
        dx      = y_q >>> iter_q;
        dy      = x_q >>> iter_q;
        dz      = $signed(atan_lut(iter_q));

        case (state_q)
            S_IDLE: begin
                if (bus.input_valid) begin
                    // fold |theta| >= pi/2 into the convergence range by a pi pre-rotation
                    if (bus.input_data_theta[TW-1] != bus.input_data_theta[TW-2]) begin
                        z_d = {~bus.input_data_theta[TW-1], bus.input_data_theta[TW-2:0]};
                        x_d = -amp_ext;
                    end else begin
                        z_d = bus.input_data_theta;
                        x_d = amp_ext;
                    end
                    y_d     = '0;
                    iter_d  = '0;
                    state_d = S_ROTATE;
                end
            end
            S_ROTATE: begin
                if (!z_q[TW-1]) begin
                    x_d = x_q - dx;
                    y_d = y_q + dy;
                    z_d = z_q - dz;
                end else begin
                    x_d = x_q + dx;
                    y_d = y_q - dy;
                    z_d = z_q + dz;
                end
                iter_d = iter_q + IW'(1);
                if (iter_q == LAST_ITER) begin
                    iter_d  = '0;
                    out_i_d = x_d;
                    out_q_d = y_d;
`ifdef CORDIC_ROTATOR_GAIN_COMP_EN
                    state_d = S_SCALE;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef CORDIC_ROTATOR_GAIN_COMP_EN
            S_SCALE: begin
                out_i_d = gain_comp(out_i_q);
                out_q_d = gain_comp(out_q_q);
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                if (bus.output_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rdy_d = (state_d == S_IDLE);
        vld_d = (state_d == S_DONE);
    end

    assign bus.input_ready       = rdy_q;
    assign bus.output_data_valid = vld_q;
    assign bus.output_data_i     = out_i_q;
    assign bus.output_data_q     = out_q_q;
endmodule

// File: tb/tb_cordic_rotator.sv
// Self-checking bench for cordic_rotator: directed vector table, backpressure,
// async reset mid-rotation, and random samples against a floating-point model.
module tb_cordic_rotator;
    localparam int unsigned DW   = 16;
    localparam int unsigned TW   = 16;
    localparam int unsigned ITER = 14;
    localparam real K  = 1.6467602;
    localparam real PI = 3.14159265358979;
`ifdef CORDIC_ROTATOR_GAIN_COMP_EN
    localparam real G   = K * 19898.0 / 32768.0;
    localparam int  LAT = ITER + 1;
`else
    localparam real G   = K;
    localparam int  LAT = ITER;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    cordic_rotator_if #(.DATA_WIDTH(DW), .THETA_WIDTH(TW)) bus ();

    cordic_rotator #(.DATA_WIDTH(DW), .THETA_WIDTH(TW), .ITERATIONS(ITER)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int  amp;
        int  theta;
        real ci;     // amp*cos(theta), hand-computed
        real cq;     // amp*sin(theta), hand-computed
        int  tol;
        bit  chk_q;
    } vec_t;

    typedef struct {
        int amp;
        int theta;
    } smp_t;

    vec_t vecs[6];
    smp_t sent_q[$];

    task automatic check_val(input string name, input int act, input int exp, input int tol);
        n_checks++;
        if ((act - exp > tol) || (exp - act > tol)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive one sample, return result and edges from accept to valid
    task automatic run_vec(input int amp, input int theta, output int ri, output int rq,
                           output int lat);
        int guard;
        bus.input_data_amp   = 16'(amp);
        bus.input_data_theta = 16'(theta);
        bus.input_valid      = 1'b1;
        guard = 0;
        while (!bus.input_ready && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        bus.input_valid = 1'b0;
        lat = 0;
        while (!bus.output_data_valid && lat < 100) begin
            tick();
            lat++;
        end
        ri = int'(bus.output_data_i);
        rq = int'(bus.output_data_q);
    endtask

    int ri, rq, lat, i0, q0, good, extra;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{10000,      0,  10000.0,     0.0,     4, 1'b1};
        vecs[1] = '{10000,  16384,      0.0, 10000.0,     4, 1'b1};
        vecs[2] = '{10000,   8192,  7071.068, 7071.068, 4, 1'b1};
        vecs[3] = '{10000, -32768, -10000.0,     0.0,     4, 1'b1};
        vecs[4] = '{-32768,     0, -32768.0,     0.0,     6, 1'b0};
        vecs[5] = '{10000, -16384,      0.0, -10000.0,    4, 1'b1};

        reset                = 1'b1;
        bus.input_valid      = 1'b0;
        bus.input_data_amp   = '0;
        bus.input_data_theta = '0;
        bus.output_ready     = 1'b1;
        repeat (3) tick();
        check_val("rst_valid", int'(bus.output_data_valid), 0, 0);
        check_val("rst_i", int'(bus.output_data_i), 0, 0);
        check_val("rst_q", int'(bus.output_data_q), 0, 0);
        check_val("rst_ready", int'(bus.input_ready), 1, 0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            run_vec(vecs[v].amp, vecs[v].theta, ri, rq, lat);
            check_val($sformatf("vec%0d_lat", v), lat, LAT, 0);
            check_val($sformatf("vec%0d_i", v), ri, int'(vecs[v].ci * G), vecs[v].tol);
            if (vecs[v].chk_q)
                check_val($sformatf("vec%0d_q", v), rq, int'(vecs[v].cq * G), vecs[v].tol);
            tick();
            check_val($sformatf("vec%0d_pulse", v), int'(bus.output_data_valid), 0, 0);
            tick();
        end

        // backpressure: hold result 5 cycles, ignore an input pulse meanwhile
        bus.output_ready = 1'b0;
        run_vec(10000, 8192, i0, q0, lat);
        check_val("bp_lat", lat, LAT, 0);
        good = 0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                bus.input_data_amp   = 16'(5000);
                bus.input_data_theta = 16'(0);
                bus.input_valid      = 1'b1;
            end
            if (k == 3) bus.input_valid = 1'b0;
            tick();
            if (bus.output_data_valid && !bus.input_ready &&
                int'(bus.output_data_i) == i0 && int'(bus.output_data_q) == q0)
                good++;
        end
        check_val("bp_hold_cycles", good, 5, 0);
        bus.output_ready = 1'b1;
        tick();
        check_val("bp_valid_drop", int'(bus.output_data_valid), 0, 0);
        check_val("bp_ready_back", int'(bus.input_ready), 1, 0);
        extra = 0;
        repeat (LAT + 4) begin
            tick();
            if (bus.output_data_valid) extra++;
        end
        check_val("bp_no_extra", extra, 0, 0);

        // asynchronous reset at iteration 7
        bus.input_data_amp   = 16'(12000);
        bus.input_data_theta = 16'(4000);
        bus.input_valid      = 1'b1;
        tick();
        bus.input_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("arst_i", int'(bus.output_data_i), 0, 0);
        check_val("arst_q", int'(bus.output_data_q), 0, 0);
        check_val("arst_valid", int'(bus.output_data_valid), 0, 0);
        check_val("arst_ready", int'(bus.input_ready), 1, 0);
        tick();
        reset = 1'b0;
        tick();
        run_vec(10000, 16384, ri, rq, lat);
        check_val("post_rst_lat", lat, LAT, 0);
        check_val("post_rst_i", ri, 0, 4);
        check_val("post_rst_q", rq, int'(10000.0 * G), 4);
        tick();

        // random samples with random output stalls
        fork
            begin : producer
                for (int n = 0; n < 200; n++) begin
                    smp_t s;
                    int   guard;
                    s.amp   = int'($urandom_range(0, 8192)) - 4096;
                    s.theta = int'($urandom_range(0, 65535)) - 32768;
                    bus.input_data_amp   = 16'(s.amp);
                    bus.input_data_theta = 16'(s.theta);
                    bus.input_valid      = 1'b1;
                    guard = 0;
                    while (!bus.input_ready && guard < 500) begin
                        tick();
                        guard++;
                    end
                    if (guard >= 500) begin
                        check_val("rand_accept_timeout", guard, 0, 0);
                        break;
                    end
                    tick();
                    sent_q.push_back(s);
                    bus.input_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) tick();
                end
                bus.input_valid = 1'b0;
            end
            begin : consumer
                int got, cyc;
                got = 0;
                cyc = 0;
                while (got < 200 && cyc < 20000) begin
                    tick();
                    cyc++;
                    bus.output_ready = ($urandom_range(0, 3) != 0);
                    if (bus.output_data_valid && bus.output_ready) begin
                        smp_t s;
                        real  r;
                        if (sent_q.size() == 0) begin
                            check_val("rand_unexpected_result", 1, 0, 0);
                        end else begin
                            s = sent_q.pop_front();
                            r = real'(s.theta) * PI / 32768.0;
                            check_val($sformatf("rand%0d_i", got), int'(bus.output_data_i),
                                      int'(G * real'(s.amp) * $cos(r)), 6);
                            check_val($sformatf("rand%0d_q", got), int'(bus.output_data_q),
                                      int'(G * real'(s.amp) * $sin(r)), 6);
                        end
                        got++;
                    end
                end
                check_val("rand_count", got, 200, 0);
            end
        join
        bus.output_ready = 1'b1;
        extra = 0;
        repeat (LAT + 4) begin
            tick();
            if (bus.output_data_valid) extra++;
        end
        check_val("rand_no_extra", extra, 0, 0);
        check_val("rand_queue_empty", sent_q.size(), 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
